// File: rtl/run_control.sv
// run_control: front-panel run/step/halt controller for the processor.
// Two raw pushbuttons are synchronized, debounced and edge-detected into
// one-cycle press pulses that drive a four-state FSM (IDLE/RUN/STEP/HALT).
// A retired halt instruction parks the machine in HALT until reset.
module run_control #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        startButton,
  input  logic        stepButton,
  input  logic [15:0] instruction,
  output logic        systemRunning,
  output logic        halted,
  output logic [1:0]  runState
);

  // Button lane indices inside the per-button vectors below.
  localparam int BTN_START = 0;
  localparam int BTN_STEP  = 1;
  localparam int NUM_BTN   = 2;

  // Counter value on the last mismatching cycle before the debounced level flips.
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync_p0;
  logic [NUM_BTN-1:0] sync_p1;
  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] deb_d;
  logic [NUM_BTN-1:0] press;
  logic [15:0]        deb_cnt [NUM_BTN];

  state_t state;
  state_t state_next;
  logic   run_next;
  logic   halted_next;
  logic   halt_hit;
  logic   unused_instr;

  // Halt opcode: top two bits and the middle nibble all ones.
  function automatic logic is_halt(input logic [1:0] op_hi, input logic [3:0] op_mid);
    return ({op_hi, op_mid} == 6'b11_1111);
  endfunction

  assign btn_raw[BTN_START] = startButton;
  assign btn_raw[BTN_STEP]  = stepButton;

  // Instruction bits that play no part in halt decoding.
  assign unused_instr = ^{instruction[13:8], instruction[3:0]};

  // Two-flop synchronizer per button; nothing downstream sees btn_raw directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: count consecutive cycles the synced level disagrees with the
  // debounced level; any agreeing cycle restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int b = 0; b < NUM_BTN; b++) begin
        deb_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BTN; b++) begin
        if (sync_p1[b] == deb[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_LAST) begin
          deb[b]     <= sync_p1[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + 16'd1;
        end
      end
    end
  end

  // Previous debounced level, used to find the rising edge of a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_d <= '0;
    end else begin
      deb_d <= deb;
    end
  end

  // A press is the 0->1 edge of the debounced level; releases are silent.
  assign press = deb & ~deb_d;

  // Halts only count while the processor is actually allowed to advance.
  assign halt_hit = is_halt(instruction[15:14], instruction[7:4]) && systemRunning;

  // Next-state logic; halt beats start in RUN, start beats step in IDLE.
  always_comb begin
    state_next  = state;
    run_next    = 1'b0;
    halted_next = 1'b0;
    case (state)
      IDLE: begin
        if (press[BTN_START]) begin
          state_next = RUN;
        end else if (press[BTN_STEP]) begin
          state_next = STEP;
        end
      end
      RUN: begin
        if (halt_hit) begin
          state_next = HALT;
        end else if (press[BTN_START]) begin
          state_next = IDLE;
        end
      end
      STEP: begin
        if (halt_hit) begin
          state_next = HALT;
        end else begin
          state_next = IDLE;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    run_next    = (state_next == RUN) || (state_next == STEP);
    halted_next = (state_next == HALT);
  end

  // State and status outputs update together so they never disagree.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      systemRunning <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state         <= state_next;
      systemRunning <= run_next;
      halted        <= halted_next;
    end
  end

  assign runState = state;

endmodule

// File: tb/tb_run_control.sv
// Bench for run_control with DEBOUNCE_CYCLES=4: directed scenarios followed
// by randomized button/instruction traffic, all checked against a
// history-based reference model of the synchronize/debounce/FSM behaviour.
module tb_run_control;

  localparam int D    = 4;
  localparam int MAXE = 16384;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STEP = 2;
  localparam int S_HALT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        startButton = 1'b0;
  logic        stepButton = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        systemRunning;
  logic        halted;
  logic [1:0]  runState;

  run_control #(.DEBOUNCE_CYCLES(D)) dut (
    .clock         (clock),
    .reset         (reset),
    .startButton   (startButton),
    .stepButton    (stepButton),
    .instruction   (instruction),
    .systemRunning (systemRunning),
    .halted        (halted),
    .runState      (runState)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: raw samples and debounced levels per edge.
  int e        = 0;
  int rst_edge = 0;
  bit raw_h [2][MAXE];
  bit deb_h [2][MAXE];
  int last_change [2];
  int m_state = S_IDLE;

  function automatic bit raw_at(int b, int j);
    if (j <= rst_edge) return 1'b0;
    return raw_h[b][j];
  endfunction

  function automatic bit deb_at(int b, int j);
    if (j <= rst_edge) return 1'b0;
    return deb_h[b][j];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".runState"}, 16'(runState), 16'(m_state));
    check({tag, ".systemRunning"}, 16'(systemRunning),
          16'((m_state == S_RUN) || (m_state == S_STEP)));
    check({tag, ".halted"}, 16'(halted), 16'(m_state == S_HALT));
  endtask

  // Advance the model across edge e using the inputs present before it.
  task automatic model_edge(input bit s, input bit t, input logic [15:0] ins);
    bit pulse [2];
    bit dp;
    bit flip;
    int lc;
    bit halt;
    raw_h[0][e] = s;
    raw_h[1][e] = t;
    for (int b = 0; b < 2; b++) begin
      dp       = deb_at(b, e - 1);
      pulse[b] = dp && !deb_at(b, e - 2);
      // The synced level seen at edge k is the raw level sampled at edge k-2.
      lc   = (last_change[b] > rst_edge) ? last_change[b] : rst_edge;
      flip = ((e - lc) >= D);
      for (int i = 0; i < D; i++) begin
        if (raw_at(b, e - 2 - i) == dp) flip = 1'b0;
      end
      deb_h[b][e] = flip ? !dp : dp;
      if (flip) last_change[b] = e;
    end
    halt = ({ins[15:14], ins[7:4]} == 6'h3F) && (m_state == S_RUN || m_state == S_STEP);
    case (m_state)
      S_IDLE: if (pulse[0]) m_state = S_RUN; else if (pulse[1]) m_state = S_STEP;
      S_RUN:  if (halt) m_state = S_HALT; else if (pulse[0]) m_state = S_IDLE;
      S_STEP: m_state = halt ? S_HALT : S_IDLE;
      default: m_state = S_HALT;
    endcase
  endtask

  task automatic tick();
    bit s, t, r;
    logic [15:0] ins;
    s = startButton; t = stepButton; r = reset; ins = instruction;
    @(posedge clock);
    e++;
    if (e >= MAXE - 2) begin
      $display("FAIL edge_budget observed=%0d required<%0d", e, MAXE - 2);
      $fatal(1);
    end
    if (!r) begin
      rst_edge = e;
      m_state  = S_IDLE;
    end else begin
      model_edge(s, t, ins);
    end
    #1;
    check_outputs("tick");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset between edges, check the cleared state, hold it over two edges.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    rst_edge = e;
    m_state  = S_IDLE;
    check_outputs("reset");
    ticks(2);
    reset = 1'b1;
  endtask

  initial begin
    bit found;
    int rem [2];
    last_change[0] = 0;
    last_change[1] = 0;

    // Reset state and start latency.
    apply_reset();
    startButton = 1'b1;
    ticks(6);
    check("lat_edge6.systemRunning", 16'(systemRunning), 16'd0);
    tick();
    check("lat_edge7.systemRunning", 16'(systemRunning), 16'd1);
    check("lat_edge7.runState", 16'(runState), 16'd1);
    check("lat_edge7.halted", 16'(halted), 16'd0);
    startButton = 1'b0;
    ticks(10);
    check("release_no_pulse.runState", 16'(runState), 16'd1);

    // Halt in RUN, then presses are ignored.
    instruction = 16'hC0F0;
    tick();
    instruction = 16'h0000;
    check("halt.halted", 16'(halted), 16'd1);
    check("halt.systemRunning", 16'(systemRunning), 16'd0);
    check("halt.runState", 16'(runState), 16'd3);
    startButton = 1'b1; ticks(8); startButton = 1'b0; ticks(8);
    stepButton  = 1'b1; ticks(8); stepButton  = 1'b0; ticks(8);
    check("halt_sticky.runState", 16'(runState), 16'd3);

    // Single step from IDLE.
    apply_reset();
    stepButton = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (systemRunning) found = 1'b1;
    end
    check("step_seen", 16'(found), 16'd1);
    check("step.runState", 16'(runState), 16'd2);
    tick();
    check("step_done.systemRunning", 16'(systemRunning), 16'd0);
    check("step_done.runState", 16'(runState), 16'd0);
    stepButton = 1'b0;
    ticks(10);

    // Short bounces never register.
    for (int r = 0; r < 6; r++) begin
      startButton = 1'b1; ticks(3);
      startButton = 1'b0; ticks(3);
    end
    check("bounce.systemRunning", 16'(systemRunning), 16'd0);
    check("bounce.runState", 16'(runState), 16'd0);

    // Both buttons together: start wins; second start pauses.
    startButton = 1'b1; stepButton = 1'b1;
    ticks(8);
    check("both.runState", 16'(runState), 16'd1);
    startButton = 1'b0; stepButton = 1'b0;
    ticks(10);
    startButton = 1'b1;
    ticks(8);
    check("pause.runState", 16'(runState), 16'd0);
    check("pause.systemRunning", 16'(systemRunning), 16'd0);
    startButton = 1'b0;
    ticks(10);

    // Asynchronous reset mid-RUN, then halt opcode while IDLE is ignored.
    startButton = 1'b1; ticks(8); startButton = 1'b0; ticks(8);
    check("prerst.systemRunning", 16'(systemRunning), 16'd1);
    #2;
    reset = 1'b0;
    #1;
    rst_edge = e;
    m_state  = S_IDLE;
    check("async_rst.systemRunning", 16'(systemRunning), 16'd0);
    check("async_rst.runState", 16'(runState), 16'd0);
    tick();
    reset = 1'b1;
    instruction = 16'hC0F0;
    ticks(3);
    instruction = 16'h0000;
    check("idle_halt.halted", 16'(halted), 16'd0);

    // Randomized traffic: buttons held for random spans, random opcodes.
    rem[0] = 0;
    rem[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rem[0] == 0) begin
        startButton = $urandom_range(0, 1);
        rem[0] = $urandom_range(1, 12);
      end
      if (rem[1] == 0) begin
        stepButton = $urandom_range(0, 1);
        rem[1] = $urandom_range(1, 12);
      end
      rem[0]--;
      rem[1]--;
      if ($urandom_range(0, 29) == 0)
        instruction = {2'b11, 6'($urandom), 4'hF, 4'($urandom)};
      else
        instruction = 16'($urandom);
      if ($urandom_range(0, 249) == 0) apply_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
